multicycle_addsub: RTL

MULTICYCLE_ADDSUB -- requirements
Module: multicycle_addsub

---
 rtl/addsub_pkg.sv | 18 +
 rtl/multicycle_addsub_chunk.sv | 27 ++
 rtl/multicycle_addsub.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/addsub_pkg.sv
// Shared types and constants for the multicycle add/subtract unit.
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic ADD = 1'b0;
    localparam logic SUB = 1'b1;

    // Chunk-index width; a single-chunk build still needs one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/multicycle_addsub_chunk.sv
// CHUNK-bit combinational ripple adder; also exposes the carry into its top bit
// so the word-level signed overflow can be formed on the final slice.
module addsub_chunk #(
    parameter int unsigned CHUNK = 4
) (
    input  logic [CHUNK-1:0] i_a,
    input  logic [CHUNK-1:0] i_b,
    input  logic             i_cin,
    output logic [CHUNK-1:0] o_sum_c,
    output logic             o_cout_c,
    output logic             o_c_msb_c
);

    always_comb begin : p_ripple
        logic w_carry;
        w_carry   = i_cin;
        o_sum_c   = '0;
        o_c_msb_c = 1'b0;
        for (int i = 0; i < int'(CHUNK); i++) begin
            if (i == int'(CHUNK) - 1) o_c_msb_c = w_carry;
            o_sum_c[i] = i_a[i] ^ i_b[i] ^ w_carry;
            w_carry    = (i_a[i] & i_b[i]) | (w_carry & (i_a[i] ^ i_b[i]));
        end
        o_cout_c = w_carry;
    end

endmodule

// File: rtl/multicycle_addsub.sv
// Multicycle add/subtract: one CHUNK slice per cycle, LSB first, valid/ready on both sides.
// Optional saturation on signed overflow when MULTICYCLE_ADDSUB_SAT_EN is defined.
module multicycle_addsub
    import addsub_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             m,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             v,
    output logic             z
);

    localparam int unsigned N        = WIDTH / CHUNK;
    localparam int unsigned IDX_W    = idx_width(N);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    generate
        if (WIDTH < 4 || WIDTH > 64) begin : g_bad_width
            $error("multicycle_addsub: WIDTH must be in 4..64");
        end
        if (CHUNK == 0 || (WIDTH % CHUNK) != 0) begin : g_bad_chunk
            $error("multicycle_addsub: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    state_e           r_state;
    state_e           w_state_next;
    logic [IDX_W-1:0] r_idx;
    logic [WIDTH-1:0] r_opa;
    logic [WIDTH-1:0] r_opb;
    logic [WIDTH-1:0] r_acc;
    logic             r_carry;
    logic             r_sign_a;

    logic             r_in_ready;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_s;
    logic             r_cout;
    logic             r_v;
    logic             r_z;

    logic             w_accept;
    logic             w_last;
    logic [CHUNK-1:0] w_sum;
    logic             w_cout;
    logic             w_c_msb;
    logic [WIDTH-1:0] w_res;
    logic [WIDTH-1:0] w_final;
    logic             w_v;

    addsub_chunk #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .i_a       (r_opa[CHUNK-1:0]),
        .i_b       (r_opb[CHUNK-1:0]),
        .i_cin     (r_carry),
        .o_sum_c   (w_sum),
        .o_cout_c  (w_cout),
        .o_c_msb_c (w_c_msb)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    // Next-state decode
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            IDLE: begin
                if (in_valid && r_in_ready) begin
                    w_accept     = 1'b1;
                    w_state_next = RUN;
                end
            end
            RUN: begin
                if (r_idx == LAST_IDX) begin
                    w_last       = 1'b1;
                    w_state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // New slice enters at the top so the accumulator is LSB-aligned after N steps.
    always_comb begin
        w_res   = (r_acc >> CHUNK) | (WIDTH'(w_sum) << (WIDTH - CHUNK));
        w_v     = w_c_msb ^ w_cout;
        w_final = w_res;
`ifdef MULTICYCLE_ADDSUB_SAT_EN
        if (w_v) w_final = r_sign_a ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
    end

    // Operand capture, per-chunk step and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_idx       <= '0;
            r_opa       <= '0;
            r_opb       <= '0;
            r_acc       <= '0;
            r_carry     <= 1'b0;
            r_sign_a    <= 1'b0;
            r_s         <= '0;
            r_cout      <= 1'b0;
            r_v         <= 1'b0;
            r_z         <= 1'b0;
        end else begin
            r_in_ready  <= (w_state_next == IDLE);
            r_out_valid <= (w_state_next == DONE);
            if (w_accept) begin
                r_opa    <= a;
                r_opb    <= (m == SUB) ? ~b : b;
                r_carry  <= m;
                r_sign_a <= a[WIDTH-1];
                r_acc    <= '0;
                r_idx    <= '0;
            end else if (r_state == RUN) begin
                r_opa   <= r_opa >> CHUNK;
                r_opb   <= r_opb >> CHUNK;
                r_carry <= w_cout;
                r_acc   <= w_res;
                r_idx   <= w_last ? '0 : r_idx + 1'b1;
                if (w_last) begin
                    r_s    <= w_final;
                    r_cout <= w_cout;
                    r_v    <= w_v;
                    r_z    <= (w_final == '0);
                end
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign s         = r_s;
    assign cout      = r_cout;
    assign v         = r_v;
    assign z         = r_z;

endmodule
